// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_e  - controller state encoding (HZ_RUN, HZ_MDU_BUSY)
//   hz_ctrl_t   - bundle of stall/flush/launch controls driven to the pipeline
//   X0          - architectural zero register index
//   load_use_hit- load-use detection helper
package hazard_ctrl_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned PERF_W = 32;

   localparam logic [REG_W-1:0] X0 = 5'd0;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MDU_BUSY = 1'b1
   } hz_state_e;

   typedef struct packed {
      logic stall_pc;
      logic stall_if_id;
      logic flush_if_id;
      logic stall_id_ex;
      logic flush_id_ex;
      logic stall_ex_mem;
      logic flush_ex_mem;
      logic stall_mem_wb;
      logic mdu_start;
   } hz_ctrl_t;

   // A load in EX whose destination feeds either ID source; x0 never hazards.
   function automatic logic load_use_hit(input logic             mem_read,
                                         input logic [REG_W-1:0] rd,
                                         input logic [REG_W-1:0] rs1,
                                         input logic [REG_W-1:0] rs2);
      return mem_read && (rd != X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master: pipeline side (drives stage info, receives stall/flush controls)
//   slave : hazard controller
// Stage info : rs1_id, rs2_id, rd_ex, MemRead_ex, branch_taken_ex, mdu_op_ex,
//              mdu_done, dmem_req_mem, dmem_ready
// Controls   : stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
//              stall_ex_mem, flush_ex_mem, stall_mem_wb, mdu_start, mdu_timeout
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic [REG_W-1:0] rs1_id;
   logic [REG_W-1:0] rs2_id;
   logic [REG_W-1:0] rd_ex;
   logic             MemRead_ex;
   logic             branch_taken_ex;
   logic             mdu_op_ex;
   logic             mdu_done;
   logic             dmem_req_mem;
   logic             dmem_ready;

   logic             stall_pc;
   logic             stall_if_id;
   logic             flush_if_id;
   logic             stall_id_ex;
   logic             flush_id_ex;
   logic             stall_ex_mem;
   logic             flush_ex_mem;
   logic             stall_mem_wb;
   logic             mdu_start;
   logic             mdu_timeout;

   modport master (
      output rs1_id, rs2_id, rd_ex, MemRead_ex, branch_taken_ex, mdu_op_ex,
             mdu_done, dmem_req_mem, dmem_ready,
      input  stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
             stall_ex_mem, flush_ex_mem, stall_mem_wb, mdu_start, mdu_timeout
   );

   modport slave (
      input  rs1_id, rs2_id, rd_ex, MemRead_ex, branch_taken_ex, mdu_op_ex,
             mdu_done, dmem_req_mem, dmem_ready,
      output stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
             stall_ex_mem, flush_ex_mem, stall_mem_wb, mdu_start, mdu_timeout
   );

endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: free-running hazard event counters (wrap at 2^32).
//   clk, rst          - clock, synchronous active-high reset
//   stall_i           - PC held this cycle
//   flush_i           - branch flush this cycle
//   loaduse_i         - load-use bubble this cycle
//   stall_cycles_o    - count of stalled cycles
//   flush_events_o    - count of branch flushes
//   loaduse_o         - count of load-use bubbles
module hazard_perf_cnt
   import hazard_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              loaduse_i,
   output logic [PERF_W-1:0] stall_cycles_o,
   output logic [PERF_W-1:0] flush_events_o,
   output logic [PERF_W-1:0] loaduse_o
);

   logic [PERF_W-1:0] stall_cycles_q;
   logic [PERF_W-1:0] flush_events_q;
   logic [PERF_W-1:0] loaduse_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
         loaduse_q      <= '0;
      end else begin
         if (stall_i)   stall_cycles_q <= stall_cycles_q + PERF_W'(1);
         if (flush_i)   flush_events_q <= flush_events_q + PERF_W'(1);
         if (loaduse_i) loaduse_q      <= loaduse_q + PERF_W'(1);
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_events_o = flush_events_q;
   assign loaduse_o      = loaduse_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage RV32 pipeline.
// Resolves load-use, taken-branch, multi-cycle MDU and dmem wait hazards.
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave (stage info in, stall/flush/mdu controls out)
//   perf_*   : hazard event counters, present only with HAZARD_PERF_EN defined
// Parameter MDU_MAX_CYCLES: MDU_BUSY cycles before the sticky mdu_timeout flag.
// Control outputs are combinational from state and inputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MDU_MAX_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cycles,
   output logic [PERF_W-1:0] perf_flush_events,
   output logic [PERF_W-1:0] perf_loaduse
`endif
);

   localparam int unsigned WD_W = (MDU_MAX_CYCLES > 1) ? $clog2(MDU_MAX_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYCLES - 1);

   hz_state_e        state_q, state_d;
   logic             done_pend_q, done_pend_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             timeout_q, timeout_d;

   hz_ctrl_t         ctrl_c;
   logic             wd_hit_c;
   logic             mem_wait_c;
   logic             load_use_c;

   assign mem_wait_c = hz.dmem_req_mem & ~hz.dmem_ready;
   assign load_use_c = load_use_hit(hz.MemRead_ex, hz.rd_ex, hz.rs1_id, hz.rs2_id);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HZ_RUN;
         done_pend_q <= 1'b0;
         wd_cnt_q    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_pend_q <= done_pend_d;
         wd_cnt_q    <= wd_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state and control outputs, highest-priority hazard first
   always_comb begin
      state_d     = state_q;
      done_pend_d = done_pend_q;
      wd_cnt_d    = wd_cnt_q;
      timeout_d   = timeout_q;
      ctrl_c      = '0;
      wd_hit_c    = 1'b0;

      unique case (state_q)
         HZ_RUN: begin
            wd_cnt_d    = '0;
            done_pend_d = 1'b0;
            if (mem_wait_c) begin
               ctrl_c.stall_pc     = 1'b1;
               ctrl_c.stall_if_id  = 1'b1;
               ctrl_c.stall_id_ex  = 1'b1;
               ctrl_c.stall_ex_mem = 1'b1;
               ctrl_c.stall_mem_wb = 1'b1;
            end else if (hz.mdu_op_ex && !hz.mdu_done) begin
               // Launch cycle already holds the front end and bubbles MEM
               ctrl_c.mdu_start    = 1'b1;
               ctrl_c.stall_pc     = 1'b1;
               ctrl_c.stall_if_id  = 1'b1;
               ctrl_c.stall_id_ex  = 1'b1;
               ctrl_c.flush_ex_mem = 1'b1;
               state_d             = HZ_MDU_BUSY;
            end else if (hz.branch_taken_ex) begin
               // Squashes the ID instruction, so any load-use on it is moot
               ctrl_c.flush_if_id  = 1'b1;
               ctrl_c.flush_id_ex  = 1'b1;
            end else if (load_use_c) begin
               ctrl_c.stall_pc     = 1'b1;
               ctrl_c.stall_if_id  = 1'b1;
               ctrl_c.flush_id_ex  = 1'b1;
            end
         end

         HZ_MDU_BUSY: begin
            wd_hit_c = (wd_cnt_q == WD_LAST);
            if (wd_hit_c) timeout_d = 1'b1;
            else          wd_cnt_d  = wd_cnt_q + WD_W'(1);

            if (mem_wait_c) begin
               // Remember a result that lands while MEM is waiting
               ctrl_c.stall_pc     = 1'b1;
               ctrl_c.stall_if_id  = 1'b1;
               ctrl_c.stall_id_ex  = 1'b1;
               ctrl_c.stall_ex_mem = 1'b1;
               ctrl_c.stall_mem_wb = 1'b1;
               if (hz.mdu_done) done_pend_d = 1'b1;
            end else if (hz.mdu_done || done_pend_q) begin
               // Exit cycle: nothing held, the MDU op moves on to MEM
               state_d     = HZ_RUN;
               done_pend_d = 1'b0;
               wd_cnt_d    = '0;
            end else begin
               ctrl_c.stall_pc     = 1'b1;
               ctrl_c.stall_if_id  = 1'b1;
               ctrl_c.stall_id_ex  = 1'b1;
               ctrl_c.flush_ex_mem = 1'b1;
            end
         end

         default: state_d = HZ_RUN;
      endcase

      if (rst) begin
         ctrl_c   = '0;
         wd_hit_c = 1'b0;
      end
   end

   assign hz.stall_pc     = ctrl_c.stall_pc;
   assign hz.stall_if_id  = ctrl_c.stall_if_id;
   assign hz.flush_if_id  = ctrl_c.flush_if_id;
   assign hz.stall_id_ex  = ctrl_c.stall_id_ex;
   assign hz.flush_id_ex  = ctrl_c.flush_id_ex;
   assign hz.stall_ex_mem = ctrl_c.stall_ex_mem;
   assign hz.flush_ex_mem = ctrl_c.flush_ex_mem;
   assign hz.stall_mem_wb = ctrl_c.stall_mem_wb;
   assign hz.mdu_start    = ctrl_c.mdu_start;
   // Visible in the cycle the limit is reached, then held by timeout_q
   assign hz.mdu_timeout  = ~rst & (timeout_q | wd_hit_c);

`ifdef HAZARD_PERF_EN
   // flush_if_id only comes from a branch; flush_id_ex with stall_pc only from load-use
   hazard_perf_cnt u_perf (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (ctrl_c.stall_pc),
      .flush_i        (ctrl_c.flush_if_id),
      .loaduse_i      (ctrl_c.flush_id_ex & ctrl_c.stall_pc),
      .stall_cycles_o (perf_stall_cycles),
      .flush_events_o (perf_flush_events),
      .loaduse_o      (perf_loaduse)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MDU_MAX_CYCLES=8).
// Control vector order: {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
// flush_id_ex, stall_ex_mem, flush_ex_mem, stall_mem_wb, mdu_start}.
module tb_hazard_ctrl;

   localparam logic [8:0] C_NONE   = 9'h000;
   localparam logic [8:0] C_LU     = 9'h190;
   localparam logic [8:0] C_BR     = 9'h050;
   localparam logic [8:0] C_BUSY   = 9'h1A4;
   localparam logic [8:0] C_LAUNCH = 9'h1A5;
   localparam logic [8:0] C_MW     = 9'h1AA;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_events, perf_loaduse;
`endif

   hazard_ctrl #(.MDU_MAX_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_events (perf_flush_events),
      .perf_loaduse      (perf_loaduse)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctl();
      return {hz.stall_pc, hz.stall_if_id, hz.flush_if_id, hz.stall_id_ex,
              hz.flush_id_ex, hz.stall_ex_mem, hz.flush_ex_mem, hz.stall_mem_wb,
              hz.mdu_start};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs change 1ns after the edge, outputs sampled 2ns after it
   task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic op, input logic dn,
                       input logic rq, input logic ry);
      @(posedge clk);
      #1;
      rst                = r;
      hz.MemRead_ex      = mr;
      hz.rd_ex           = rd;
      hz.rs1_id          = rs1;
      hz.rs2_id          = rs2;
      hz.branch_taken_ex = br;
      hz.mdu_op_ex       = op;
      hz.mdu_done        = dn;
      hz.dmem_req_mem    = rq;
      hz.dmem_ready      = ry;
      #1;
   endtask

   initial begin
      hz.MemRead_ex = 0; hz.rd_ex = 0; hz.rs1_id = 0; hz.rs2_id = 0;
      hz.branch_taken_ex = 0; hz.mdu_op_ex = 0; hz.mdu_done = 0;
      hz.dmem_req_mem = 0; hz.dmem_ready = 0;

      // Reset: outputs quiet even with a load-use pattern present
      step(1, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0);
      step(1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 1, 0);
      chk("reset_ctl", 32'(ctl()), 32'(C_NONE));
      chk("reset_timeout", 32'(hz.mdu_timeout), 32'd0);

      // Load-use on rs2, then the load has left EX
      step(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0);
      chk("lu_rs2", 32'(ctl()), 32'(C_LU));
      step(0, 0, 5'd0, 5'd1, 5'd5, 0, 0, 0, 0, 0);
      chk("lu_after", 32'(ctl()), 32'(C_NONE));
      // Load to x0 never stalls
      step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      chk("lu_x0", 32'(ctl()), 32'(C_NONE));
      // Load-use on rs1
      step(0, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0, 0, 0);
      chk("lu_rs1", 32'(ctl()), 32'(C_LU));
      // Non-load with matching rd
      step(0, 0, 5'd7, 5'd7, 5'd3, 0, 0, 0, 0, 0);
      chk("no_load", 32'(ctl()), 32'(C_NONE));
      // Branch overrides load-use
      step(0, 1, 5'd9, 5'd9, 5'd9, 1, 0, 0, 0, 0);
      chk("br_over_lu", 32'(ctl()), 32'(C_BR));
      // Memory wait in RUN beats branch
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0);
      chk("mw_run", 32'(ctl()), 32'(C_MW));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
      chk("mw_ready", 32'(ctl()), 32'(C_NONE));

      // Single-cycle MDU: no stall, stay in RUN
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
      chk("mdu_1cyc", 32'(ctl()), 32'(C_NONE));
      step(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 0);
      chk("mdu_1cyc_run", 32'(ctl()), 32'(C_LU));

      // Multi-cycle MDU: launch, 5 busy cycles, exit on done
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("mdu_launch", 32'(ctl()), 32'(C_LAUNCH));
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
         chk($sformatf("mdu_busy%0d", k), 32'(ctl()), 32'(C_BUSY));
      end
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
      chk("mdu_exit", 32'(ctl()), 32'(C_NONE));
      step(0, 1, 5'd6, 5'd0, 5'd6, 0, 0, 0, 0, 0);
      chk("mdu_back_run", 32'(ctl()), 32'(C_LU));

      // Memory wait overlapping MDU_BUSY with done in the 2nd wait cycle
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("ov_launch", 32'(ctl()), 32'(C_LAUNCH));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("ov_busy", 32'(ctl()), 32'(C_BUSY));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0);
      chk("ov_mw1", 32'(ctl()), 32'(C_MW));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0);
      chk("ov_mw2", 32'(ctl()), 32'(C_MW));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0);
      chk("ov_mw3", 32'(ctl()), 32'(C_MW));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1);
      chk("ov_exit", 32'(ctl()), 32'(C_NONE));
      step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
      chk("ov_back_run", 32'(ctl()), 32'(C_BR));
      chk("ov_no_timeout", 32'(hz.mdu_timeout), 32'd0);

      // Watchdog: done never arrives, flag rises on the 8th busy cycle
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("wd_launch", 32'(ctl()), 32'(C_LAUNCH));
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
         chk($sformatf("wd_busy%0d", k), 32'(ctl()), 32'(C_BUSY));
         chk($sformatf("wd_timeout%0d", k), 32'(hz.mdu_timeout), (k >= 8) ? 32'd1 : 32'd0);
      end
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
      chk("wd_exit", 32'(ctl()), 32'(C_NONE));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      chk("wd_sticky", 32'(hz.mdu_timeout), 32'd1);

      // Reset mid-MDU with a pending done captured during a memory wait
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("rm_launch", 32'(ctl()), 32'(C_LAUNCH));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0);
      chk("rm_mw_done", 32'(ctl()), 32'(C_MW));
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("rm_rst_ctl", 32'(ctl()), 32'(C_NONE));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      chk("rm_after_ctl", 32'(ctl()), 32'(C_NONE));
      chk("rm_after_timeout", 32'(hz.mdu_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("rm_perf_stall", perf_stall_cycles, 32'd0);
      chk("rm_perf_flush", perf_flush_events, 32'd0);
      chk("rm_perf_lu", perf_loaduse, 32'd0);
`endif
      // Pending done must not survive reset: new op stays busy
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("rm_relaunch", 32'(ctl()), 32'(C_LAUNCH));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
      chk("rm_busy", 32'(ctl()), 32'(C_BUSY));
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0);
      chk("rm_exit", 32'(ctl()), 32'(C_NONE));
      step(0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, 0, 0);
      chk("rm_run_lu", 32'(ctl()), 32'(C_LU));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It works alongside the EX-stage operand forwarding mux and covers the hazards forwarding cannot resolve:
- load-use stalls
- taken-branch/jump flushes
- multi-cycle MDU ops in EX
- data-memory wait states in MEM

It drives stall (hold) and flush (bubble) enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MDU_MAX_CYCLES, 64: watchdog limit on cycles spent in MDU_BUSY before mdu_timeout asserts.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- rd_ex  in  5  EX-stage destination register
- MemRead_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  EX resolved taken branch/jump (PC redirect)
- mdu_op_ex  in  1  EX holds a mul/div op
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- dmem_req_mem  in  1  MEM stage issuing a dmem access
- dmem_ready  in  1  dmem access completes this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID to NOP
- stall_id_ex  out  1  hold ID/EX
- flush_id_ex  out  1  clear ID/EX to NOP
- stall_ex_mem  out  1  hold EX/MEM
- flush_ex_mem  out  1  clear EX/MEM to NOP
- stall_mem_wb  out  1  hold MEM/WB
- mdu_start  out  1  one-cycle launch pulse to MDU
- mdu_timeout  out  1  sticky watchdog flag

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- States: RUN, MDU_BUSY. Reset -> RUN; done_pend=0; wd_cnt=0; mdu_timeout=0.
- Outputs are combinational from state plus inputs. With rst=1, all stall/flush outputs and mdu_start are 0.
- Signal definitions:
  - mem_wait = dmem_req_mem & ~dmem_ready.
  - load_use = MemRead_ex & (rd_ex!=0) & (rd_ex==rs1_id | rd_ex==rs2_id).
- Priority, highest first:
  1. mem_wait, in any state: all five stall_* = 1; no flushes; mdu_start=0; state held.
  2. MDU_BUSY: stall_pc, stall_if_id, stall_id_ex = 1; flush_ex_mem=1 (bubble to MEM); MEM/WB advances.
  3. RUN with branch_taken_ex: flush_if_id=1 and flush_id_ex=1; no stalls. This overrides load_use, since the ID instruction is squashed.
  4. RUN with load_use: stall_pc=1, stall_if_id=1, flush_id_ex=1. Exactly one bubble, because the load leaves EX next cycle.
- MDU launch (RUN):
  - mdu_op_ex & ~mem_wait & ~mdu_done: mdu_start=1 for one cycle; go to MDU_BUSY next cycle. Priority-2 outputs already apply in the launch cycle.
  - mdu_done in the same cycle as the op (single-cycle MDU): no stall, stay in RUN.
- MDU_BUSY exit:
  - On (mdu_done | done_pend) & ~mem_wait: -> RUN; clear done_pend. In that cycle no stalls, so the op advances to MEM.
  - mdu_done arriving while mem_wait: set done_pend; the exit happens once mem_wait drops.
- Watchdog: wd_cnt increments each cycle in MDU_BUSY and clears on entry to RUN. When wd_cnt == MDU_MAX_CYCLES-1, mdu_timeout is set. It is sticky until rst; the state machine itself is unaffected.
- A mid-operation rst returns the block to RUN, drops done_pend, and produces no stray mdu_start.
- rd_ex==x0 never triggers load_use.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cycles[31:0], perf_flush_events[31:0] and perf_loaduse[31:0].
  - Sync reset to 0; wrap at 2^32.
  - perf_stall_cycles increments in any cycle with stall_pc=1.
  - perf_flush_events increments on each branch flush.
  - perf_loaduse increments on each load-use bubble.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- isa.v additions: state encodings HZ_RUN and HZ_MDU_BUSY; X0 constant 5'd0.
- One natural sub-module: hazard_perf_cnt (the three counters), instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: lw x5 in EX (MemRead_ex=1, rd_ex=5), rs2_id=5 -> one cycle with stall_pc=1, stall_if_id=1, flush_id_ex=1, then all 0. Repeat with rd_ex=0 -> no stall.
- Branch vs load-use: branch_taken_ex=1 with a load_use condition present -> flush_if_id=1, flush_id_ex=1, stall_pc=0.
- MDU: mdu_op_ex=1, mdu_done after 5 cycles -> mdu_start pulse in cycle 0; 5 cycles of MDU_BUSY stalls with flush_ex_mem=1; cycle 6 no stalls, state RUN.
- Mem wait overlap: dmem_ready=0 for 3 cycles while in MDU_BUSY, with mdu_done pulsing in the 2nd of those cycles -> all stalls for 3 cycles; exit to RUN on the cycle dmem_ready=1.
- Watchdog: MDU_MAX_CYCLES=8, mdu_done never arrives -> mdu_timeout rises on the 8th MDU_BUSY cycle and stays high until rst.
- Reset mid-MDU: rst=1 for one cycle in MDU_BUSY -> next cycle in RUN, all outputs 0, no mdu_start. Under HAZARD_PERF_EN, the counters read 0.
